intpol2_squared_acc: RTL and testbench
======================================

// Module: intpol2_squared_acc
// PURPOSE
//  Generalised squared-term generator for the quadratic interpolator, for factor L=2**LOG2_L and NCH channels.
//  Per accepted coefficient x2 it emits L samples xi2[k]=x2*k^2, k=0..L-1, built by finite differences (no multipliers).
//  Sits between the coefficient stage and the polynomial summer. Uses valid/ready on both sides, stalls, and back-to-back blocks.
// PARAMETERS
//  DATA_WIDTH  32  base sample width
//  N_BITS      2   guard bits; IN_W = DATA_WIDTH+N_BITS
//  LOG2_L      2   log2 of interpolation factor (>=1); L = 2**LOG2_L
//  NCH         1   parallel channels, all sharing one schedule
//  OUT_W = IN_W+2*LOG2_L (full precision); IN_W when INTPOL2_SQ_SCALE_EN is defined
// PORTS
//  clk      in   1           clock, all state on rising edge
//  rstn     in   1           asynchronous active-low reset
//  clear    in   1           synchronous clear; same effect as reset
//  s_valid  in   1           x2 valid
//  s_ready  out  1           block can take a new x2
//  x2       in   NCH*IN_W    signed coefficients, channel c at [c*IN_W +: IN_W]
//  m_valid  out  1           xi2 valid
//  m_ready  in   1           downstream accepts xi2
//  xi2      out  NCH*OUT_W   signed squared terms, channel c at [c*OUT_W +: OUT_W]
//  k_idx    out  LOG2_L      phase index k of the current xi2
//  last     out  1           high when k_idx==L-1 and m_valid
// BEHAVIOUR
//  Reset/clear: FSM=IDLE, m_valid=0, xi2=0, k_idx=0, last=0. Pending block is discarded. clear wins over every other input.
//  FSM IDLE: s_ready=1. On s_valid, latch x2 per channel, set f=0 and d=x2, go to RUN.
//    The first output (k=0, xi2=0) has m_valid=1 on the next cycle (latency 1).
//  FSM RUN: xi2/k_idx/last stay stable while m_valid&!m_ready.
//    On m_valid&m_ready with k<L-1: f<=f+d, d<=d+2*x2, k<=k+1.
//    Result: f(k)=x2*k^2, and second difference constant = 2*x2.
//  End of block: on m_ready while last=1:
//    s_valid=1 starts the next block in the same cycle (no bubble), k_idx back to 0;
//    otherwise go to IDLE and m_valid drops next cycle.
//  s_ready = IDLE | (m_valid & m_ready & last). Combinational, with no path from s_valid.
//  x2 is sampled only on s_valid&s_ready and held for the whole block; later x2 changes are ignored.
//  Widths: d is IN_W+LOG2_L+1 bits and f is IN_W+2*LOG2_L bits, both signed. All arithmetic sign-extended; no overflow possible.
//    Worst case f = -2^(IN_W-1)*(L-1)^2, which fits.
//  Channels are independent datapaths under one shared FSM/counter; one output handshake advances all channels.
//  m_valid=0 -> xi2 holds its last value (not re-zeroed).
// CONFIGURATION
//  INTPOL2_SQ_SCALE_EN defined:
//    output is x2*(k/L)^2 = floor((f + 2^(2*LOG2_L-1)) >>> 2*LOG2_L), i.e. round half up, truncated to OUT_W=IN_W.
//    Adds no cycles; the rounding is combinational on f.
//  Not defined: xi2 = f, full precision, OUT_W = IN_W+2*LOG2_L.
// TESTING (LOG2_L=2, NCH=2 unless noted)
//  T1 x2={3,-5}, m_ready=1 -> ch0 0,3,12,27; ch1 0,-5,-20,-45; k_idx 0..3; last only at k=3; then IDLE.
//  T2 s_valid held with new x2={1,2} during T1 -> second block starts the cycle after the last=1 beat.
//     Outputs 0,1,4,9 / 0,2,8,18, with no m_valid gap.
//  T3 m_ready toggles 1,0,0,1,... -> xi2/k_idx stay frozen during stall cycles; sequence identical to T1.
//  T4 x2 = -2^(IN_W-1) on both channels, LOG2_L=3 -> k=7 gives -49*2^(IN_W-1), exact, no wrap.
//  T5 clear, or rstn low, asserted at k=2 -> next cycle m_valid=0, k_idx=0, s_ready=1.
//     The next block starts from k=0 with the new x2.
//  T6 SCALE_EN, x2={3,-5} -> ch0 0,0,1,2; ch1 0,0,-1,-3.

Source files
------------

// File: rtl/intpol2_squared_acc.sv
// Squared-term generator for the quadratic interpolator: emits x2*k^2 for k=0..L-1 by finite differences.
// Optional INTPOL2_SQ_SCALE_EN: output is rounded x2*(k/L)^2 at IN_W bits instead of full precision.
module intpol2_squared_acc #(
    parameter int DATA_WIDTH = 32,
    parameter int N_BITS     = 2,
    parameter int LOG2_L     = 2,
    parameter int NCH        = 1,
    localparam int IN_W      = DATA_WIDTH + N_BITS,
`ifdef INTPOL2_SQ_SCALE_EN
    localparam int OUT_W     = IN_W
`else
    localparam int OUT_W     = IN_W + 2 * LOG2_L
`endif
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   clear,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [NCH*IN_W-1:0]    x2,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [NCH*OUT_W-1:0]   xi2,
    output logic [LOG2_L-1:0]      k_idx,
    output logic                   last
);

    localparam int L   = 2 ** LOG2_L;
    localparam int D_W = IN_W + LOG2_L + 1;
    localparam int F_W = IN_W + 2 * LOG2_L;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [LOG2_L-1:0] K_LAST = LOG2_L'(L - 1);

    logic [0:0]               state;
    logic [LOG2_L-1:0]        k;
    logic signed [IN_W-1:0]   x2_in [NCH];
    logic signed [IN_W-1:0]   x2_r  [NCH];
    logic signed [D_W-1:0]    d_r   [NCH];
    logic signed [F_W-1:0]    f_r   [NCH];
    logic                     beat;
    logic                     take;

    assign m_valid = (state == ST_RUN);
    assign k_idx   = k;
    assign last    = m_valid && (k == K_LAST);
    assign beat    = m_valid && m_ready;
    assign s_ready = (state == ST_IDLE) || (beat && last);
    assign take    = s_valid && s_ready;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        assign x2_in[c] = x2[c*IN_W +: IN_W];
`ifdef INTPOL2_SQ_SCALE_EN
        localparam logic signed [F_W-1:0] HALF = F_W'(1) <<< (2 * LOG2_L - 1);
        assign xi2[c*OUT_W +: OUT_W] = OUT_W'((f_r[c] + HALF) >>> (2 * LOG2_L));
`else
        assign xi2[c*OUT_W +: OUT_W] = f_r[c];
`endif
    end

    // f walks x2*k^2; d is the next first difference x2*(2k+1), growing by 2*x2 per beat.
    // A new block may start on the same edge that retires the last beat of the previous one.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
            k     <= '0;
            for (int c = 0; c < NCH; c++) begin
                x2_r[c] <= '0;
                d_r[c]  <= '0;
                f_r[c]  <= '0;
            end
        end else if (clear) begin
            state <= ST_IDLE;
            k     <= '0;
            for (int c = 0; c < NCH; c++) begin
                x2_r[c] <= '0;
                d_r[c]  <= '0;
                f_r[c]  <= '0;
            end
        end else if (take) begin
            state <= ST_RUN;
            k     <= '0;
            for (int c = 0; c < NCH; c++) begin
                x2_r[c] <= x2_in[c];
                d_r[c]  <= D_W'(x2_in[c]);
                f_r[c]  <= '0;
            end
        end else if (beat) begin
            if (last) begin
                state <= ST_IDLE;
                k     <= '0;
            end else begin
                k <= k + LOG2_L'(1);
                for (int c = 0; c < NCH; c++) begin
                    f_r[c] <= f_r[c] + F_W'(d_r[c]);
                    d_r[c] <= d_r[c] + (D_W'(x2_r[c]) <<< 1);
                end
            end
        end
    end

endmodule

// File: tb/tb_intpol2_squared_acc.sv
// Directed bench for intpol2_squared_acc: LOG2_L=2/NCH=2 main instance plus a LOG2_L=3 instance for the extreme-value case.
module tb_intpol2_squared_acc;

    localparam int DW   = 14;
    localparam int NB   = 2;
    localparam int IN_W = DW + NB;
`ifdef INTPOL2_SQ_SCALE_EN
    localparam int OUT_A = IN_W;
    localparam int OUT_B = IN_W;
`else
    localparam int OUT_A = IN_W + 4;
    localparam int OUT_B = IN_W + 6;
`endif

    logic clk;
    logic rstn;
    logic clear;

    logic               s_valid_a, s_ready_a, m_valid_a, m_ready_a, last_a;
    logic [2*IN_W-1:0]  x2_a;
    logic [2*OUT_A-1:0] xi2_a;
    logic [1:0]         k_idx_a;

    logic               s_valid_b, s_ready_b, m_valid_b, m_ready_b, last_b;
    logic [2*IN_W-1:0]  x2_b;
    logic [2*OUT_B-1:0] xi2_b;
    logic [2:0]         k_idx_b;

    logic signed [OUT_A-1:0] a0, a1;
    logic signed [OUT_B-1:0] b0, b1;

    int checks;
    int errors;

    assign a0 = xi2_a[OUT_A-1:0];
    assign a1 = xi2_a[2*OUT_A-1:OUT_A];
    assign b0 = xi2_b[OUT_B-1:0];
    assign b1 = xi2_b[2*OUT_B-1:OUT_B];

    intpol2_squared_acc #(.DATA_WIDTH(DW), .N_BITS(NB), .LOG2_L(2), .NCH(2)) dut_a (
        .clk(clk), .rstn(rstn), .clear(clear),
        .s_valid(s_valid_a), .s_ready(s_ready_a), .x2(x2_a),
        .m_valid(m_valid_a), .m_ready(m_ready_a), .xi2(xi2_a),
        .k_idx(k_idx_a), .last(last_a)
    );

    intpol2_squared_acc #(.DATA_WIDTH(DW), .N_BITS(NB), .LOG2_L(3), .NCH(2)) dut_b (
        .clk(clk), .rstn(rstn), .clear(clear),
        .s_valid(s_valid_b), .s_ready(s_ready_b), .x2(x2_b),
        .m_valid(m_valid_b), .m_ready(m_ready_b), .xi2(xi2_b),
        .k_idx(k_idx_b), .last(last_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference value by direct multiplication (and floor rounding when scaled).
    function automatic longint exp_sq(input longint x, input int k, input int lg);
        longint f;
        f = x * k * k;
`ifdef INTPOL2_SQ_SCALE_EN
        f = (f + (64'sd1 <<< (2 * lg - 1))) >>> (2 * lg);
`endif
        return f;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_a(input longint x0, input longint x1);
        s_valid_a = 1'b1;
        x2_a = {IN_W'(x1), IN_W'(x0)};
        step();
        s_valid_a = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0; clear = 1'b0;
        s_valid_a = 1'b0; m_ready_a = 1'b0; x2_a = '0;
        s_valid_b = 1'b0; m_ready_b = 1'b0; x2_b = '0;
        #3;
        checks++; if (m_valid_a !== 1'b0) begin errors++; $display("[TB] FAIL reset m_valid: got %b expected 0", m_valid_a); end
        checks++; if (k_idx_a !== 2'd0) begin errors++; $display("[TB] FAIL reset k_idx: got %0d expected 0", k_idx_a); end
        checks++; if (last_a !== 1'b0) begin errors++; $display("[TB] FAIL reset last: got %b expected 0", last_a); end
        checks++; if (xi2_a !== '0) begin errors++; $display("[TB] FAIL reset xi2: got %h expected 0", xi2_a); end
        checks++; if (s_ready_a !== 1'b1) begin errors++; $display("[TB] FAIL reset s_ready: got %b expected 1", s_ready_a); end
        step();
        rstn = 1'b1;
        step();
    endtask

    task automatic test_single_block();
        m_ready_a = 1'b1;
        #1;
        checks++; if (s_ready_a !== 1'b1) begin errors++; $display("[TB] FAIL t1 idle s_ready: got %b expected 1", s_ready_a); end
        start_a(3, -5);
        for (int k = 0; k < 4; k++) begin
            checks++; if (m_valid_a !== 1'b1) begin errors++; $display("[TB] FAIL t1 m_valid k=%0d: got %b expected 1", k, m_valid_a); end
            checks++; if (k_idx_a !== 2'(k)) begin errors++; $display("[TB] FAIL t1 k_idx: got %0d expected %0d", k_idx_a, k); end
            checks++; if (last_a !== (k == 3)) begin errors++; $display("[TB] FAIL t1 last k=%0d: got %b expected %b", k, last_a, k == 3); end
            checks++; if (s_ready_a !== (k == 3)) begin errors++; $display("[TB] FAIL t1 s_ready k=%0d: got %b expected %b", k, s_ready_a, k == 3); end
            checks++; if (a0 !== OUT_A'(exp_sq(3, k, 2))) begin errors++; $display("[TB] FAIL t1 ch0 k=%0d: got %0d expected %0d", k, a0, exp_sq(3, k, 2)); end
            checks++; if (a1 !== OUT_A'(exp_sq(-5, k, 2))) begin errors++; $display("[TB] FAIL t1 ch1 k=%0d: got %0d expected %0d", k, a1, exp_sq(-5, k, 2)); end
            step();
        end
        checks++; if (m_valid_a !== 1'b0) begin errors++; $display("[TB] FAIL t1 end m_valid: got %b expected 0", m_valid_a); end
        checks++; if (a0 !== OUT_A'(exp_sq(3, 3, 2))) begin errors++; $display("[TB] FAIL t1 hold ch0: got %0d expected %0d", a0, exp_sq(3, 3, 2)); end
        checks++; if (s_ready_a !== 1'b1) begin errors++; $display("[TB] FAIL t1 end s_ready: got %b expected 1", s_ready_a); end
    endtask

    task automatic test_back_to_back();
        longint xs0, xs1;
        m_ready_a = 1'b1;
        s_valid_a = 1'b1;
        x2_a = {IN_W'(-5), IN_W'(3)};
        step();
        x2_a = {IN_W'(2), IN_W'(1)};
        for (int blk = 0; blk < 2; blk++) begin
            xs0 = (blk == 0) ? 3 : 1;
            xs1 = (blk == 0) ? -5 : 2;
            for (int k = 0; k < 4; k++) begin
                checks++; if (m_valid_a !== 1'b1) begin errors++; $display("[TB] FAIL t2 m_valid blk=%0d k=%0d: got %b expected 1", blk, k, m_valid_a); end
                checks++; if (k_idx_a !== 2'(k)) begin errors++; $display("[TB] FAIL t2 k_idx blk=%0d: got %0d expected %0d", blk, k_idx_a, k); end
                checks++; if (a0 !== OUT_A'(exp_sq(xs0, k, 2))) begin errors++; $display("[TB] FAIL t2 ch0 blk=%0d k=%0d: got %0d expected %0d", blk, k, a0, exp_sq(xs0, k, 2)); end
                checks++; if (a1 !== OUT_A'(exp_sq(xs1, k, 2))) begin errors++; $display("[TB] FAIL t2 ch1 blk=%0d k=%0d: got %0d expected %0d", blk, k, a1, exp_sq(xs1, k, 2)); end
                step();
                if (blk == 0 && k == 3) s_valid_a = 1'b0;
            end
        end
        checks++; if (m_valid_a !== 1'b0) begin errors++; $display("[TB] FAIL t2 end m_valid: got %b expected 0", m_valid_a); end
    endtask

    task automatic test_stall();
        int k;
        int cyc;
        k = 0;
        cyc = 0;
        m_ready_a = 1'b0;
        start_a(3, -5);
        while (k < 4 && cyc < 40) begin
            m_ready_a = (cyc % 3 == 0);
            checks++; if (m_valid_a !== 1'b1) begin errors++; $display("[TB] FAIL t3 m_valid cyc=%0d: got %b expected 1", cyc, m_valid_a); end
            checks++; if (k_idx_a !== 2'(k)) begin errors++; $display("[TB] FAIL t3 k_idx cyc=%0d: got %0d expected %0d", cyc, k_idx_a, k); end
            checks++; if (a0 !== OUT_A'(exp_sq(3, k, 2))) begin errors++; $display("[TB] FAIL t3 ch0 cyc=%0d: got %0d expected %0d", cyc, a0, exp_sq(3, k, 2)); end
            checks++; if (a1 !== OUT_A'(exp_sq(-5, k, 2))) begin errors++; $display("[TB] FAIL t3 ch1 cyc=%0d: got %0d expected %0d", cyc, a1, exp_sq(-5, k, 2)); end
            step();
            if (m_ready_a) k++;
            cyc++;
        end
        checks++; if (k != 4) begin errors++; $display("[TB] FAIL t3 timeout: got %0d beats expected 4", k); end
        checks++; if (m_valid_a !== 1'b0) begin errors++; $display("[TB] FAIL t3 end m_valid: got %b expected 0", m_valid_a); end
        m_ready_a = 1'b1;
    endtask

    task automatic test_extreme();
        longint xm;
        xm = -(64'sd1 <<< (IN_W - 1));
        m_ready_b = 1'b1;
        s_valid_b = 1'b1;
        x2_b = {IN_W'(xm), IN_W'(xm)};
        step();
        s_valid_b = 1'b0;
        for (int k = 0; k < 8; k++) begin
            checks++; if (k_idx_b !== 3'(k)) begin errors++; $display("[TB] FAIL t4 k_idx: got %0d expected %0d", k_idx_b, k); end
            checks++; if (last_b !== (k == 7)) begin errors++; $display("[TB] FAIL t4 last k=%0d: got %b expected %b", k, last_b, k == 7); end
            checks++; if (b0 !== OUT_B'(exp_sq(xm, k, 3))) begin errors++; $display("[TB] FAIL t4 ch0 k=%0d: got %0d expected %0d", k, b0, exp_sq(xm, k, 3)); end
            checks++; if (b1 !== OUT_B'(exp_sq(xm, k, 3))) begin errors++; $display("[TB] FAIL t4 ch1 k=%0d: got %0d expected %0d", k, b1, exp_sq(xm, k, 3)); end
            step();
        end
        checks++; if (m_valid_b !== 1'b0) begin errors++; $display("[TB] FAIL t4 end m_valid: got %b expected 0", m_valid_b); end
    endtask

    task automatic test_abort();
        for (int mode = 0; mode < 2; mode++) begin
            m_ready_a = 1'b1;
            start_a(5, -7);
            step();
            step();
            checks++; if (k_idx_a !== 2'd2) begin errors++; $display("[TB] FAIL t5 pre-abort k_idx mode=%0d: got %0d expected 2", mode, k_idx_a); end
            if (mode == 0) begin
                clear = 1'b1;
                s_valid_a = 1'b1;
                x2_a = {IN_W'(9), IN_W'(9)};
                step();
                clear = 1'b0;
                s_valid_a = 1'b0;
            end else begin
                rstn = 1'b0;
                #2;
            end
            checks++; if (m_valid_a !== 1'b0) begin errors++; $display("[TB] FAIL t5 m_valid mode=%0d: got %b expected 0", mode, m_valid_a); end
            checks++; if (k_idx_a !== 2'd0) begin errors++; $display("[TB] FAIL t5 k_idx mode=%0d: got %0d expected 0", mode, k_idx_a); end
            checks++; if (s_ready_a !== 1'b1) begin errors++; $display("[TB] FAIL t5 s_ready mode=%0d: got %b expected 1", mode, s_ready_a); end
            checks++; if (xi2_a !== '0) begin errors++; $display("[TB] FAIL t5 xi2 mode=%0d: got %h expected 0", mode, xi2_a); end
            rstn = 1'b1;
            step();
            start_a(7, -1);
            for (int k = 0; k < 4; k++) begin
                checks++; if (k_idx_a !== 2'(k)) begin errors++; $display("[TB] FAIL t5 restart k_idx mode=%0d: got %0d expected %0d", mode, k_idx_a, k); end
                checks++; if (a0 !== OUT_A'(exp_sq(7, k, 2))) begin errors++; $display("[TB] FAIL t5 restart ch0 mode=%0d k=%0d: got %0d expected %0d", mode, k, a0, exp_sq(7, k, 2)); end
                checks++; if (a1 !== OUT_A'(exp_sq(-1, k, 2))) begin errors++; $display("[TB] FAIL t5 restart ch1 mode=%0d k=%0d: got %0d expected %0d", mode, k, a1, exp_sq(-1, k, 2)); end
                step();
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single_block();
        test_back_to_back();
        test_stall();
        test_extreme();
        test_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
